ring_seq_monitor: RTL
=====================

Name: ring_seq_monitor

Overview:
- Downstream consumer of the one-hot ring counter output.
- Samples the ring word every clock and decodes it to a binary phase index.
- Checks one-hot legality and correct rotation order, detects stuck state, and counts completed revolutions.
- Drives phase-sequenced logic and system fault reporting.

Parameters:
- WIDTH, 4: ring width in bits (>=2).
- SHIFT_LEFT, 1: expected rotation. 1: next = {r[WIDTH-2:0], r[WIDTH-1]}. 0: rotate right.
- STUCK_LIMIT, 3: number of consecutive identical samples that flags stuck (>=2).
- REV_W, 8: width of the revolution counter.

Ports:
- Clock  input  1  rising-edge clock, same as the ring counter.
- Reset  input  1  asynchronous, active-high reset.
- Ring_in  input  WIDTH  ring counter Count_out.
- Clear_err  input  1  synchronous clear of the sticky error flags.
- Phase_idx  output  clog2(WIDTH)  registered binary index of the hot bit.
- Phase_valid  output  1  Phase_idx is valid (sample was one-hot).
- Rev_count  output  REV_W  completed revolutions, wraps modulo 2^REV_W.
- Err_onehot  output  1  sticky: a sample was not one-hot (zero or multiple bits set).
- Err_seq  output  1  sticky: a legal one-hot sample was not the expected successor.
- Err_stuck  output  1  sticky: the same sample repeated STUCK_LIMIT times.
- Fault  output  1  OR of the three sticky errors, registered.

Behaviour:
- Reset (asynchronous): all outputs are 0. Internal state is also cleared: prev sample = 0, primed = 0, stuck counter = 0.
- Latency: every output reflects the Ring_in sampled at the previous rising edge (1 cycle).
- One-hot check: legal means exactly one bit set.
  - Legal: Phase_valid = 1, Phase_idx = position of the set bit.
  - Illegal: Phase_valid = 0, Phase_idx holds its last value, Err_onehot set.
- Primed: set at the first clock after Reset deasserts. Sequence and stuck checks run only when primed = 1 and both prev and current samples are legal.
- Sequence check:
  - current == rotate(prev): correct advance. Stuck counter reloads to 1.
  - current == prev: hold. Stuck counter increments and saturates at STUCK_LIMIT.
  - Otherwise: Err_seq set and stuck counter reloads to 1.
- Stuck: Err_stuck is set on the edge where the stuck counter reaches STUCK_LIMIT. Example: STUCK_LIMIT = 3 means the 3rd identical consecutive sample.
- Illegal sample: stuck counter resets to 0. The next legal sample is not sequence-checked against the illegal one; it re-primes the comparison.
- Revolution: Rev_count increments by 1 on a correct advance from phase WIDTH-1 to phase 0 (SHIFT_LEFT = 1). For SHIFT_LEFT = 0 it is phase 0 to WIDTH-1. It wraps from 2^REV_W-1 to 0. It never increments on a sequence error or on the first primed sample.
- Sticky errors: once set, they stay set until Clear_err or Reset.
  - If Clear_err and a new error condition occur in the same cycle, the error wins (flag stays 1).
  - Clear_err does not affect Rev_count, Phase_idx or the stuck counter.
- Fault: registered OR of the next-state error flags, so it asserts in the same cycle as the flag.
- Reset mid-operation: immediate return to the reset values. The first post-reset sample is never flagged for sequence, even if it is not phase 0.

Decomposition:
- Shared package (ring_pkg):
  - constants RING_W = 4 and PH_W = clog2(RING_W);
  - function rotate_next(word, dir);
  - function onehot_to_idx(word), returning the index plus a legal flag.
- One natural sub-module: ring_onehot_decoder. It is combinational: input word, outputs idx and legal, with the popcount==1 check.
- The monitor itself holds the sample register, stuck counter, revolution counter and error flags.

Test Plan:
- Normal run, WIDTH=4, SHIFT_LEFT=1: reset, then drive 0001, 0010, 0100, 1000, 0001 and repeat for 3 laps. Expect Phase_idx 0,1,2,3,0 one cycle delayed, Rev_count = 3, all errors 0.
- Illegal word: inject 0110 mid-sequence. Expect the next cycle Phase_valid = 0 and Err_onehot = 1 (Fault = 1). Then resume with 0100 and expect no Err_seq.
- Skip: drive 0001 then 0100. Expect Err_seq = 1 and Rev_count unchanged. Assert Clear_err for 1 cycle during legal rotation, then expect Err_seq = 0 and Fault = 0.
- Stuck: hold 0010 for 3 clocks. Expect Err_stuck = 1 on the 3rd sample edge; holding 2 clocks only gives Err_stuck = 0.
- Clear_err coincident with a new 0000 sample: expect Err_onehot to remain 1.
- Async Reset pulsed mid-lap (not on a clock edge): expect all outputs 0 immediately. A first post-reset sample of 0100 raises no Err_seq.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared constants, types and helpers for the one-hot ring sequence monitor.
// Helpers work on a MAX_W-wide container so any ring width up to MAX_W can reuse them.
package ring_pkg;

  localparam int RING_W = 4;
  localparam int PH_W   = $clog2(RING_W);
  localparam int MAX_W  = 32;
  localparam int IDX_W  = $clog2(MAX_W);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             legal;
  } onehot_res_t;

  typedef enum logic [1:0] {
    SEQ_NONE = 2'd0,
    SEQ_ADV  = 2'd1,
    SEQ_HOLD = 2'd2,
    SEQ_ERR  = 2'd3
  } seq_kind_e;

  // Expected successor of a one-hot word inside a ring of 'width' bits; dir=1 rotates left.
  function automatic logic [MAX_W-1:0] rotate_next(input logic [MAX_W-1:0] word,
                                                   input int unsigned      width,
                                                   input logic             dir);
    logic [MAX_W-1:0] mask;
    if (width >= MAX_W) mask = '1;
    else                mask = (MAX_W'(1) << width) - MAX_W'(1);
    if (dir) return ((word << 1) | (word >> (width - 1))) & mask;
    else     return ((word >> 1) | (word << (width - 1))) & mask;
  endfunction

  function automatic onehot_res_t onehot_to_idx(input logic [MAX_W-1:0] word);
    onehot_res_t res;
    int unsigned cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (word[i]) begin
        cnt     = cnt + 1;
        res.idx = IDX_W'(i);
      end
    end
    res.legal = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/ring_seq_monitor_decoder.sv
// Combinational one-hot decoder: binary index of the set bit plus a popcount==1 legality flag.
module ring_onehot_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_W
) (
  input  logic [WIDTH-1:0]         i_word,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_legal
);

  localparam int PW = $clog2(WIDTH);

  onehot_res_t w_res;

  always_comb w_res = onehot_to_idx(MAX_W'(i_word));

  assign o_idx   = PW'(w_res.idx);
  assign o_legal = w_res.legal;

endmodule

// File: rtl/ring_seq_monitor.sv
// Monitors a one-hot ring counter: decodes the phase, checks legality, rotation order and
// stuck state, counts revolutions. Every output reflects the sample taken at the previous edge.
module ring_seq_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH       = RING_W,
  parameter int SHIFT_LEFT  = 1,
  parameter int STUCK_LIMIT = 3,
  parameter int REV_W       = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [WIDTH-1:0]         i_ring_in,
  input  logic                     i_clear_err,
  output logic [$clog2(WIDTH)-1:0] o_phase_idx,
  output logic                     o_phase_valid,
  output logic [REV_W-1:0]         o_rev_count,
  output logic                     o_err_onehot,
  output logic                     o_err_seq,
  output logic                     o_err_stuck,
  output logic                     o_fault
);

  localparam int PW = $clog2(WIDTH);
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [PW-1:0] WRAP_IDX  = (SHIFT_LEFT != 0) ? '0 : PW'(WIDTH - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_LIMIT);

  logic [WIDTH-1:0] r_prev;
  logic             r_prev_legal;
  logic             r_primed;
  logic [SW-1:0]    r_stuck_cnt;
  logic [REV_W-1:0] r_rev;
  logic [PW-1:0]    r_phase_idx;
  logic             r_phase_valid;
  logic             r_err_onehot;
  logic             r_err_seq;
  logic             r_err_stuck;
  logic             r_fault;

  logic [PW-1:0]    w_cur_idx;
  logic             w_cur_legal;
  logic             w_checked;
  seq_kind_e        w_kind;
  logic [SW-1:0]    w_stuck_nxt;
  logic             w_stuck_hit;
  logic             w_rev_inc;
  logic             w_eoh_nxt;
  logic             w_eseq_nxt;
  logic             w_estk_nxt;

  ring_onehot_decoder #(.WIDTH(WIDTH)) u_dec (
    .i_word  (i_ring_in),
    .o_idx   (w_cur_idx),
    .o_legal (w_cur_legal)
  );

  // Only a legal sample following a legal, primed sample is compared; anything else re-primes.
  assign w_checked = r_primed & r_prev_legal & w_cur_legal;

  always_comb begin
    w_kind = SEQ_NONE;
    if (w_checked) begin
      if (MAX_W'(i_ring_in) == rotate_next(MAX_W'(r_prev), WIDTH, SHIFT_LEFT != 0))
        w_kind = SEQ_ADV;
      else if (i_ring_in == r_prev)
        w_kind = SEQ_HOLD;
      else
        w_kind = SEQ_ERR;
    end
  end

  always_comb begin
    w_stuck_nxt = r_stuck_cnt;
    w_stuck_hit = 1'b0;
    if (!w_cur_legal) begin
      w_stuck_nxt = '0;
    end else if (w_kind == SEQ_HOLD) begin
      if (r_stuck_cnt < STUCK_MAX) begin
        w_stuck_nxt = r_stuck_cnt + 1'b1;
        w_stuck_hit = (w_stuck_nxt == STUCK_MAX);
      end
    end else begin
      w_stuck_nxt = SW'(1);
    end
  end

  assign w_rev_inc  = (w_kind == SEQ_ADV) && (w_cur_idx == WRAP_IDX);
  // A new error in the same cycle as a clear keeps the flag set.
  assign w_eoh_nxt  = ~w_cur_legal         | (r_err_onehot & ~i_clear_err);
  assign w_eseq_nxt = (w_kind == SEQ_ERR)  | (r_err_seq    & ~i_clear_err);
  assign w_estk_nxt = w_stuck_hit          | (r_err_stuck  & ~i_clear_err);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev        <= '0;
      r_prev_legal  <= 1'b0;
      r_primed      <= 1'b0;
      r_stuck_cnt   <= '0;
      r_rev         <= '0;
      r_phase_idx   <= '0;
      r_phase_valid <= 1'b0;
      r_err_onehot  <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_stuck   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_prev        <= i_ring_in;
      r_prev_legal  <= w_cur_legal;
      r_primed      <= 1'b1;
      r_stuck_cnt   <= w_stuck_nxt;
      if (w_rev_inc) r_rev <= r_rev + 1'b1;
      if (w_cur_legal) r_phase_idx <= w_cur_idx;
      r_phase_valid <= w_cur_legal;
      r_err_onehot  <= w_eoh_nxt;
      r_err_seq     <= w_eseq_nxt;
      r_err_stuck   <= w_estk_nxt;
      r_fault       <= w_eoh_nxt | w_eseq_nxt | w_estk_nxt;
    end
  end

  assign o_phase_idx   = r_phase_idx;
  assign o_phase_valid = r_phase_valid;
  assign o_rev_count   = r_rev;
  assign o_err_onehot  = r_err_onehot;
  assign o_err_seq     = r_err_seq;
  assign o_err_stuck   = r_err_stuck;
  assign o_fault       = r_fault;

endmodule
